// File: rtl/fetch_program_loader_ctrl.sv
// Debug-link program loader: assembles UART bytes into instruction words,
// writes them to instruction memory, then drives the pipeline enable (run/step).
module fetch_program_loader_ctrl #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_halt,
  output logic             o_mem_wr_en,
  output logic [NBITS-1:0] o_mem_addr,
  output logic [NBITS-1:0] o_mem_data,
  output logic             o_enable,
  output logic             o_loaded,
  output logic             o_load_err,
  output logic             o_done,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [NBITS-1:0] ADDR_LIMIT = NBITS'(MEM_WORDS * 4);

  state_t           r_state, r_state_nxt;
  logic [NBITS-1:0] r_addr;
  logic [NBITS-1:0] r_mem_addr;
  logic [NBITS-1:0] r_mem_data;
  logic [1:0]       r_bcnt;
  logic [23:0]      r_asm;
  logic             r_loaded;
  logic             r_load_err;
  logic             r_step;

  logic [NBITS-1:0] w_addr_nxt;
  logic             w_marker;
  logic             w_byte_l, w_byte_c, w_byte_s, w_byte_n, w_byte_q;

  assign w_addr_nxt = r_addr + NBITS'(4);
  assign w_marker   = (r_mem_data == '1);
  assign w_byte_l   = i_rx_valid && (i_rx_data == 8'h4C);
  assign w_byte_c   = i_rx_valid && (i_rx_data == 8'h43);
  assign w_byte_s   = i_rx_valid && (i_rx_data == 8'h53);
  assign w_byte_n   = i_rx_valid && (i_rx_data == 8'h4E);
  assign w_byte_q   = i_rx_valid && (i_rx_data == 8'h51);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_byte_l)                  r_state_nxt = S_LOAD;
        else if (w_byte_c && r_loaded) r_state_nxt = S_RUN;
        else if (w_byte_s && r_loaded) r_state_nxt = S_STEP;
      end
      S_LOAD:  if (i_rx_valid && r_bcnt == 2'd3) r_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_marker || w_addr_nxt == ADDR_LIMIT) r_state_nxt = S_IDLE;
        else                                      r_state_nxt = S_LOAD;
      end
      S_RUN:   if (i_halt) r_state_nxt = S_DONE;
      S_STEP: begin
        if (i_halt)        r_state_nxt = S_DONE;
        else if (w_byte_q) r_state_nxt = S_IDLE;
      end
      default: r_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_wr_en = (r_state == S_WRITE);
    o_done      = (r_state == S_DONE);
    o_state     = r_state;
    o_enable    = 1'b0;
    case (r_state)
      S_RUN:   o_enable = !i_halt;
      S_STEP:  o_enable = r_step && !i_halt;
      default: o_enable = 1'b0;
    endcase
  end

  // A byte landing in WRITE becomes byte 0 of the next word so back-to-back bytes are never dropped.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_bcnt     <= '0;
      r_asm      <= '0;
      r_loaded   <= 1'b0;
      r_load_err <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_step <= (r_state == S_STEP) && w_byte_n && !i_halt;
      case (r_state)
        S_IDLE: begin
          if (w_byte_l) begin
            r_addr     <= '0;
            r_bcnt     <= '0;
            r_asm      <= '0;
            r_loaded   <= 1'b0;
            r_load_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (i_rx_valid) begin
            case (r_bcnt)
              2'd0: begin r_asm[7:0]   <= i_rx_data; r_bcnt <= 2'd1; end
              2'd1: begin r_asm[15:8]  <= i_rx_data; r_bcnt <= 2'd2; end
              2'd2: begin r_asm[23:16] <= i_rx_data; r_bcnt <= 2'd3; end
              default: begin
                r_mem_data <= NBITS'({i_rx_data, r_asm});
                r_mem_addr <= r_addr;
                r_bcnt     <= '0;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_addr <= w_addr_nxt;
          if (i_rx_valid) begin
            r_asm[7:0] <= i_rx_data;
            r_bcnt     <= 2'd1;
          end
          if (w_marker)                      r_loaded   <= 1'b1;
          else if (w_addr_nxt == ADDR_LIMIT) r_load_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_loaded   = r_loaded;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_fetch_program_loader_ctrl.sv
// Directed + randomized bench for fetch_program_loader_ctrl: two instances
// (default depth and a 4-word memory) checked against a transaction-level model.
module tb_fetch_program_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rxv_a, rxv_b;
  logic        halt;

  logic        wr_a, en_a, loaded_a, err_a, done_a;
  logic [31:0] addr_a, data_a;
  logic [2:0]  st_a;
  logic        wr_b, en_b, loaded_b, err_b, done_b;
  logic [31:0] addr_b, data_b;
  logic [2:0]  st_b;

  fetch_program_loader_ctrl #(.NBITS(32), .MEM_WORDS(256)) u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rxv_a), .i_halt(halt),
    .o_mem_wr_en(wr_a), .o_mem_addr(addr_a), .o_mem_data(data_a), .o_enable(en_a),
    .o_loaded(loaded_a), .o_load_err(err_a), .o_done(done_a), .o_state(st_a)
  );

  fetch_program_loader_ctrl #(.NBITS(32), .MEM_WORDS(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rxv_b), .i_halt(halt),
    .o_mem_wr_en(wr_b), .o_mem_addr(addr_b), .o_mem_data(data_b), .o_enable(en_b),
    .o_loaded(loaded_b), .o_load_err(err_b), .o_done(done_b), .o_state(st_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         qa[$];
  wr_t         qb[$];
  logic [31:0] wlist[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] safe_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 127));
    if (b inside {8'h43, 8'h4C, 8'h4E, 8'h51, 8'h53}) b = 8'h20;
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    return {safe_byte(), safe_byte(), safe_byte(), safe_byte()};
  endfunction

  // Advance one clock, then check any memory write against the expected write queues.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wr_a) begin
      if (qa.size() == 0) chk("wr_a_unexpected", 32'(wr_a), 32'd0);
      else begin
        e = qa.pop_front();
        chk("wr_a_addr", addr_a, e.addr);
        chk("wr_a_data", data_a, e.data);
      end
    end
    if (wr_b) begin
      if (qb.size() == 0) chk("wr_b_unexpected", 32'(wr_b), 32'd0);
      else begin
        e = qb.pop_front();
        chk("wr_b_addr", addr_b, e.addr);
        chk("wr_b_data", data_b, e.data);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input bit on_b, input logic [7:0] b);
    rx_data = b;
    if (on_b) rxv_b = 1'b1;
    else      rxv_a = 1'b1;
    tick();
    rxv_a   = 1'b0;
    rxv_b   = 1'b0;
    rx_data = 8'h00;
  endtask

  // Model: words land at 0,4,8..; the marker ends the load, reaching the depth limit flags an error.
  task automatic do_load(input bit on_b, input bit rand_gap, input int unsigned mem_words);
    logic [31:0] addr;
    logic [31:0] w;
    bit          stop;
    bit          exp_l;
    bit          exp_e;
    wr_t         e;
    addr = 0; stop = 0; exp_l = 0; exp_e = 0;
    foreach (wlist[i]) begin
      if (!stop) begin
        e.addr = addr;
        e.data = wlist[i];
        if (on_b) qb.push_back(e);
        else      qa.push_back(e);
        if (wlist[i] == 32'hFFFF_FFFF) begin
          exp_l = 1; stop = 1;
        end else begin
          addr += 4;
          if (addr == mem_words * 4) begin
            exp_e = 1; stop = 1;
          end
        end
      end
    end
    send(on_b, 8'h4C);
    foreach (wlist[i]) begin
      w = wlist[i];
      for (int k = 0; k < 4; k++) begin
        send(on_b, w[8*k +: 8]);
        if (rand_gap) idle($urandom_range(0, 2));
      end
    end
    idle(3);
    if (on_b) begin
      chk("load_b_pending_writes", 32'(qb.size()), 32'd0);
      chk("load_b_loaded", 32'(loaded_b), 32'(exp_l));
      chk("load_b_err", 32'(err_b), 32'(exp_e));
      chk("load_b_state", 32'(st_b), 32'd0);
    end else begin
      chk("load_a_pending_writes", 32'(qa.size()), 32'd0);
      chk("load_a_loaded", 32'(loaded_a), 32'(exp_l));
      chk("load_a_err", 32'(err_a), 32'(exp_e));
      chk("load_a_state", 32'(st_a), 32'd0);
    end
  endtask

  // Run for n enabled cycles (an 'L' is injected mid-run), then halt.
  task automatic do_run(input int n);
    rx_data = 8'h43; rxv_a = 1'b1;
    tick();
    rxv_a = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("run_enable", 32'(en_a), 32'd1);
      chk("run_state", 32'(st_a), 32'd3);
      if (i == 2) begin rx_data = 8'h4C; rxv_a = 1'b1; end
      tick();
      rxv_a = 1'b0;
    end
    halt = 1'b1;
    #1;
    chk("run_halt_gate", 32'(en_a), 32'd0);
    tick();
    chk("run_done_pulse", 32'(done_a), 32'd1);
    chk("run_done_enable", 32'(en_a), 32'd0);
    chk("run_done_state", 32'(st_a), 32'd5);
    halt = 1'b0;
    tick();
    chk("run_after_done", 32'(done_a), 32'd0);
    chk("run_after_state", 32'(st_a), 32'd0);
    chk("run_after_loaded", 32'(loaded_a), 32'd1);
  endtask

  initial begin
    logic [15:0] pat;
    rst_n = 1'b1; rx_data = '0; rxv_a = 1'b0; rxv_b = 1'b0; halt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_addr", addr_a, 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_flags", {28'd0, en_a, loaded_a, err_a, done_a}, 32'd0);
    chk("rst_b_state", 32'(st_b), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Commands before any program is loaded
    send(0, 8'h43);
    chk("noload_c_state", 32'(st_a), 32'd0);
    chk("noload_c_en", 32'(en_a), 32'd0);
    send(0, 8'h53);
    chk("noload_s_state", 32'(st_a), 32'd0);
    send(0, 8'h7A);
    chk("noload_junk_state", 32'(st_a), 32'd0);
    chk("noload_junk_en", 32'(en_a), 32'd0);

    // Directed program, bytes back to back
    wlist = '{32'h2000_0013, 32'h2000_0004, 32'hFFFF_FFFF};
    do_load(0, 0, 256);

    do_run(10);

    // Step mode: enable pulse follows each 'N' by one cycle; 0x7A is noise
    send(0, 8'h53);
    chk("step_entry_state", 32'(st_a), 32'd4);
    chk("step_entry_en", 32'(en_a), 32'd0);
    pat = 16'($urandom) | 16'h0421;
    for (int c = 0; c < 16; c++) begin
      rx_data = pat[c] ? 8'h4E : 8'h7A;
      rxv_a   = 1'b1;
      tick();
      rxv_a   = 1'b0;
      chk("step_enable", 32'(en_a), 32'(pat[c]));
      chk("step_state", 32'(st_a), 32'd4);
    end
    send(0, 8'h51);
    chk("step_quit_en", 32'(en_a), 32'd0);
    chk("step_quit_state", 32'(st_a), 32'd0);

    // Halt during a pending step pulse
    send(0, 8'h53);
    rx_data = 8'h4E; rxv_a = 1'b1;
    @(posedge clk);
    #1;
    rxv_a = 1'b0;
    halt  = 1'b1;
    #1;
    chk("step_halt_suppress", 32'(en_a), 32'd0);
    tick();
    chk("step_halt_done", 32'(done_a), 32'd1);
    chk("step_halt_state", 32'(st_a), 32'd5);
    halt = 1'b0;
    tick();
    chk("step_halt_idle", 32'(st_a), 32'd0);
    chk("step_halt_loaded", 32'(loaded_a), 32'd1);

    // Overflow on the 4-word instance: five data words, no marker
    wlist = {};
    for (int i = 0; i < 5; i++) wlist.push_back(rand_word());
    do_load(1, 1, 4);

    // Asynchronous reset mid-load discards the partial word
    send(0, 8'h4C);
    send(0, safe_byte());
    send(0, safe_byte());
    #2 rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(st_a), 32'd0);
    chk("abort_wr", 32'(wr_a), 32'd0);
    chk("abort_addr", addr_a, 32'd0);
    chk("abort_data", data_a, 32'd0);
    chk("abort_flags", {28'd0, en_a, loaded_a, err_a, done_a}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    wlist = {};
    for (int i = 0; i < 3; i++) wlist.push_back(rand_word());
    wlist.push_back(32'hFFFF_FFFF);
    do_load(0, 1, 256);

    do_run(int'($urandom_range(4, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_program_loader_ctrl.md
Name: fetch_program_loader_ctrl

Overview:
Sequences the instruction-fetch stage from the debug link. It assembles bytes from the UART receiver into 32-bit instruction words and writes them into instruction memory through the memory write port. After loading, it drives the pipeline enable, either continuously until the program halts or one cycle per step command. It sits between the UART RX block and the fetch stage's memory-write and enable inputs.

Parameters:
NBITS, 32, instruction and address width
MEM_WORDS, 256, instruction memory depth in words; the byte-address limit is MEM_WORDS*4

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_halt  in  1  halt instruction has retired in the pipeline (level)
o_mem_wr_en  out  1  instruction memory write strobe
o_mem_addr  out  NBITS  byte write address
o_mem_data  out  NBITS  write data
o_enable  out  1  pipeline/PC enable
o_loaded  out  1  a complete program is resident
o_load_err  out  1  load overflowed memory (sticky until the next 'L')
o_done  out  1  one-cycle pulse when a run ends on halt
o_state  out  3  current state, for debug

Behaviour:
- One clock domain. i_rst is asynchronous and active-low. While i_rst is low, the state is IDLE and all outputs, the address counter, the byte counter and the assembly register are 0.
- States (o_state encoding): IDLE=0, LOAD=1, WRITE=2, RUN=3, STEP=4, DONE=5.
- Only bytes with i_rx_valid=1 are consumed. Unlisted bytes are ignored in every state.
- IDLE:
  - 0x4C 'L' goes to LOAD. It clears the address counter, the byte counter, o_loaded and o_load_err.
  - 0x43 'C' goes to RUN, only if o_loaded=1.
  - 0x53 'S' goes to STEP, only if o_loaded=1.
- LOAD:
  - Bytes arrive LSB first. Byte k (0..3) goes to bits [8k+7:8k].
  - On the 4th byte: the word is latched into o_mem_data, o_mem_addr takes the address counter, the byte counter returns to 0, and the state goes to WRITE.
- WRITE (exactly one cycle):
  - o_mem_wr_en=1 and the address counter increments by 4.
  - A byte arriving in this cycle is accepted into the assembly register as byte 0; no byte is lost.
  - If the word is 0xFFFFFFFF (halt marker): the marker itself is written, o_loaded goes to 1, and the state goes to IDLE.
  - Else, if the incremented address equals MEM_WORDS*4: o_load_err goes to 1, o_loaded stays 0, and the state goes to IDLE.
  - Otherwise the state returns to LOAD.
- o_mem_wr_en is 1 only in WRITE.
- RUN: o_enable=1 every cycle. i_halt=1 sets o_enable=0 in that same cycle (combinational gating) and goes to DONE. RX bytes are ignored.
- STEP:
  - o_enable=0 by default.
  - Each 0x4E 'N' gives exactly one o_enable=1 cycle, registered, in the cycle after the strobe.
  - 0x51 'Q' goes to IDLE.
  - i_halt=1 goes to DONE, and a pending step pulse is suppressed.
  - 'N' strobes on consecutive cycles give consecutive enable cycles.
- DONE (one cycle): o_done=1, o_enable=0, then IDLE. o_loaded stays 1, so the program can be rerun.
- An 'L' received while in RUN or STEP is ignored; reload is only possible from IDLE.
- Reset asserted mid-load or mid-run aborts immediately. A partially assembled word is discarded and never written.
- Address arithmetic is NBITS wide. Overflow is detected against MEM_WORDS*4 before any write beyond the end can occur.

Test Plan:
1. Reset, then 'L' followed by bytes 13 00 00 20, 04 00 00 20, FF FF FF FF → three writes: addr 0 data 0x20000013, addr 4 data 0x20000004, addr 8 data 0xFFFFFFFF. o_loaded=1 afterwards, state IDLE.
2. After test 1, send 'C' and assert i_halt 10 cycles later → o_enable=1 for exactly 10 cycles, then a one-cycle o_done, then IDLE with o_loaded still 1.
3. After test 1, send 'S', then 'N' three times with gaps, then 'Q' → exactly three single-cycle o_enable pulses, each one cycle after its strobe, then state IDLE.
4. With MEM_WORDS=4, load five non-marker words → writes only at addresses 0, 4, 8, 12. o_load_err=1, o_loaded=0, and the fifth word is never written.
5. 'L' then 2 bytes, then pull i_rst low asynchronously (mid-cycle) → outputs go to 0 immediately with no o_mem_wr_en. A subsequent full load starts at addr 0.
6. In IDLE before any load, send 'C', 'S' and 0x7A → state stays IDLE and o_enable stays 0. During RUN, an 'L' byte is ignored.
